// File: rtl/game_pkg.sv
// Shared frame-buffer constants and types for the VRAM arbiter slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package game_pkg;

  localparam int ADDR_W      = 17;     // 320x240 frame = 76800 words
  localparam int DATA_W      = 12;     // 4:4:4 RGB
  localparam int FRAME_WORDS = 76800;  // words written by one clear

  typedef logic [DATA_W-1:0] pixel_t;

  // Clear engine states
  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_CLEAR = 1'b1
  } clr_state_t;

  // Round-robin turn between game-logic writes and the clear engine
  typedef enum logic {
    RR_WRITE_NEXT = 1'b0,
    RR_CLEAR_NEXT = 1'b1
  } rr_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// Bundle of scanout, write, clear and VRAM port signals around the arbiter.
// Latency: n/a (wiring only).
// Backpressure: wr_valid/wr_ready on the write path; scanout is never stalled.
interface vram_arbiter_if #(
  parameter int ADDR_W = game_pkg::ADDR_W,
  parameter int DATA_W = game_pkg::DATA_W
);

  // VGA scanout read port
  logic              scan_req;
  logic [ADDR_W-1:0] scan_addr;
  logic [DATA_W-1:0] scan_rdata;
  logic              scan_rvalid;

  // Game-logic write port
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // Frame clear control
  logic              clr_start;
  logic [DATA_W-1:0] clr_color;
  logic              clr_busy;

  // Single-port VRAM
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  scan_req, scan_addr,
    output scan_rdata, scan_rvalid,
    input  wr_valid, wr_addr, wr_data,
    output wr_ready,
    input  clr_start, clr_color,
    output clr_busy,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Client / memory side
  modport master (
    output scan_req, scan_addr,
    input  scan_rdata, scan_rvalid,
    output wr_valid, wr_addr, wr_data,
    input  wr_ready,
    output clr_start, clr_color,
    input  clr_busy,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/vram_clear_engine.sv
// Frame clear engine: walks addresses 0..FRAME_WORDS-1 writing a latched color.
// Latency: clr_busy/clr_req rise the cycle after clr_start; one word per granted cycle.
// Backpressure: holds its address while clr_gnt is low; clr_start ignored while busy.
module vram_clear_engine #(
  parameter int ADDR_W      = game_pkg::ADDR_W,
  parameter int DATA_W      = game_pkg::DATA_W,
  parameter int FRAME_WORDS = game_pkg::FRAME_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_color,
  output logic              clr_req,
  input  logic              clr_gnt,
  output logic [ADDR_W-1:0] clr_addr,
  output logic [DATA_W-1:0] clr_data,
  output logic              clr_busy
);
  import game_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

  clr_state_t        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q;
  logic [DATA_W-1:0] color_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= CLR_IDLE;
    else     state_q <= state_d;
  end

  // Next state: start on clr_start, finish after the grant that writes the last word
  always_comb begin
    state_d = state_q;
    case (state_q)
      CLR_IDLE:  if (clr_start) state_d = CLR_CLEAR;
      CLR_CLEAR: if (clr_gnt && (cnt_q == LAST_ADDR)) state_d = CLR_IDLE;
      default:   state_d = CLR_IDLE;
    endcase
  end

  // Address counter and fill color; counter only advances on a grant
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      color_q <= '0;
    end else if ((state_q == CLR_IDLE) && clr_start) begin
      cnt_q   <= '0;
      color_q <= clr_color;
    end else if ((state_q == CLR_CLEAR) && clr_gnt) begin
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  assign clr_req  = (state_q == CLR_CLEAR);
  assign clr_busy = (state_q == CLR_CLEAR);
  assign clr_addr = cnt_q;
  assign clr_data = color_q;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scanout reads beat a round-robin write/clear pair.
// Latency: write/clear same cycle; scan_rdata one cycle after scan_req.
// Backpressure: wr_ready drops while scanout or the clear owns the port; scanout never stalls.
// Optional VRAM_ARBITER_STATS_EN adds a saturating 16-bit write-stall counter.
module vram_arbiter #(
  parameter int ADDR_W      = game_pkg::ADDR_W,
  parameter int DATA_W      = game_pkg::DATA_W,
  parameter int FRAME_WORDS = game_pkg::FRAME_WORDS
) (
  input  logic          clk,
  input  logic          rst,
  vram_arbiter_if.slave bus
`ifdef VRAM_ARBITER_STATS_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);
  import game_pkg::*;

  logic              clr_req;
  logic              clr_gnt;
  logic              clr_busy_i;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] clr_data;

  logic              scan_gnt;
  logic              wr_ready_i;
  logic              wr_fire;
  logic              scan_rvalid_q;
  rr_t               rr_q;

  logic              mem_en_i;
  logic              mem_we_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [DATA_W-1:0] mem_wdata_i;

  vram_clear_engine #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .FRAME_WORDS (FRAME_WORDS)
  ) u_clear (
    .clk       (clk),
    .rst       (rst),
    .clr_start (bus.clr_start),
    .clr_color (bus.clr_color),
    .clr_req   (clr_req),
    .clr_gnt   (clr_gnt),
    .clr_addr  (clr_addr),
    .clr_data  (clr_data),
    .clr_busy  (clr_busy_i)
  );

  // Ownership: scan first; otherwise the write is offered the port unless it is the
  // clear's turn, and the clear takes any cycle the write leaves unused.
  always_comb begin
    scan_gnt   = !rst && bus.scan_req;
    wr_ready_i = !rst && !bus.scan_req && (!clr_req || (rr_q == RR_WRITE_NEXT));
    wr_fire    = wr_ready_i && bus.wr_valid;
    clr_gnt    = !rst && !bus.scan_req && clr_req && !wr_fire;
  end

  // VRAM port mux; address/data are zeroed when idle to keep the bus quiet
  always_comb begin
    mem_en_i    = 1'b0;
    mem_we_i    = 1'b0;
    mem_addr_i  = '0;
    mem_wdata_i = '0;
    if (scan_gnt) begin
      mem_en_i    = 1'b1;
      mem_addr_i  = bus.scan_addr;
    end else if (wr_fire) begin
      mem_en_i    = 1'b1;
      mem_we_i    = 1'b1;
      mem_addr_i  = bus.wr_addr;
      mem_wdata_i = bus.wr_data;
    end else if (clr_gnt) begin
      mem_en_i    = 1'b1;
      mem_we_i    = 1'b1;
      mem_addr_i  = clr_addr;
      mem_wdata_i = clr_data;
    end
  end

  // Round-robin turn flips only when someone actually gets the port
  always_ff @(posedge clk) begin
    if (rst)          rr_q <= RR_WRITE_NEXT;
    else if (wr_fire) rr_q <= RR_CLEAR_NEXT;
    else if (clr_gnt) rr_q <= RR_WRITE_NEXT;
  end

  // Read-valid tracks the one-cycle VRAM read latency
  always_ff @(posedge clk) begin
    if (rst) scan_rvalid_q <= 1'b0;
    else     scan_rvalid_q <= bus.scan_req;
  end

  assign bus.scan_rvalid = scan_rvalid_q;
  assign bus.scan_rdata  = scan_rvalid_q ? bus.mem_rdata : '0;
  assign bus.wr_ready    = wr_ready_i;
  assign bus.clr_busy    = clr_busy_i;
  assign bus.mem_en      = mem_en_i;
  assign bus.mem_we      = mem_we_i;
  assign bus.mem_addr    = mem_addr_i;
  assign bus.mem_wdata   = mem_wdata_i;

`ifdef VRAM_ARBITER_STATS_EN
  // Count cycles a write is presented but not accepted, saturating
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (bus.wr_valid && !wr_ready_i && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: vector table, randomized traffic against a memory model,
// clear / clear-with-writes / reset-abort sequences and, when enabled, the stall counter.
module tb_vram_arbiter;
  import game_pkg::*;

  localparam int AW  = 11;
  localparam int DW  = 12;
  localparam int FW  = 1100;
  localparam int MEM = 2048;

  logic clk;
  logic rst;
  logic mem_init;

  vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

`ifdef VRAM_ARBITER_STATS_EN
  logic [15:0] stall_cnt;
`endif

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FRAME_WORDS(FW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef VRAM_ARBITER_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- VRAM behavioural model (one-cycle read latency) ----------------
  logic [DW-1:0] vram [0:MEM-1];
  logic [DW-1:0] mem_rdata_q;

  function automatic logic [DW-1:0] init_pat(input int i);
    return DW'((i * 37 + 5) ^ (i >> 3));
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < MEM; i++) vram[i] <= init_pat(i);
    end else if (bus.mem_en) begin
      if (bus.mem_we) vram[bus.mem_addr] <= bus.mem_wdata;
      else            mem_rdata_q <= vram[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = mem_rdata_q;

  // ---------------- reference contents and scoreboard counters ----------------
  logic [DW-1:0] ref_mem [0:MEM-1];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic idle_inputs();
    bus.scan_req  = 1'b0;
    bus.wr_valid  = 1'b0;
    bus.clr_start = 1'b0;
  endtask

  // Pipelined scan reads of [lo,hi], each compared with the reference contents
  task automatic scan_range(input int lo, input int hi);
    logic          exp_v;
    logic [DW-1:0] exp_d;
    exp_v = 1'b0;
    exp_d = '0;
    for (int a = lo; a <= hi + 1; a++) begin
      @(negedge clk);
      idle_inputs();
      if (a <= hi) begin
        bus.scan_req  = 1'b1;
        bus.scan_addr = AW'(a);
      end
      #1;
      if (exp_v) begin
        chk("scan_rvalid", 32'(bus.scan_rvalid), 32'd1);
        chk($sformatf("scan_rdata@%0d", a - 1), 32'(bus.scan_rdata), 32'(exp_d));
      end
      exp_v = (a <= hi);
      if (a <= hi) exp_d = ref_mem[a];
    end
  endtask

  // Random scan/write traffic with the clear idle; force_scan holds scan_req=1
  task automatic run_mix(input int n, input bit force_scan);
    logic          exp_v;
    logic [DW-1:0] exp_d;
    logic          sr;
    exp_v = 1'b0;
    exp_d = '0;
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      idle_inputs();
      sr = (i < n) && (force_scan || ($urandom_range(0, 1) == 1));
      bus.scan_req  = sr;
      bus.scan_addr = AW'($urandom_range(0, FW + 100));
      bus.wr_valid  = (i < n) && (force_scan || ($urandom_range(0, 2) != 0));
      bus.wr_addr   = AW'($urandom_range(0, FW + 100));
      bus.wr_data   = DW'($urandom);
      #1;
      chk("rvalid_follows_req", 32'(bus.scan_rvalid), 32'(exp_v));
      if (exp_v) chk("mix_rdata", 32'(bus.scan_rdata), 32'(exp_d));
      chk("wr_ready_vs_scan", 32'(bus.wr_ready), 32'(!sr));
      if (sr) chk("scan_no_write", 32'(bus.mem_we), 32'd0);
      exp_v = sr;
      if (sr) exp_d = ref_mem[bus.scan_addr];
      else if (bus.wr_valid) ref_mem[bus.wr_addr] = bus.wr_data;
    end
  endtask

  typedef struct {
    logic          scan_req;
    logic          wr_valid;
    logic [AW-1:0] scan_addr;
    logic [AW-1:0] wr_addr;
    pixel_t        wr_data;
    logic          exp_en;
    logic          exp_we;
    logic          exp_rdy;
    logic [AW-1:0] exp_addr;
  } vec_t;

  vec_t vecs [6];

  initial begin : main
    int            n, k, bad, done, alt_bad, last, cur, wk;
    logic          fire, prev_fire;

    vecs[0] = '{1'b1, 1'b1, 11'h010, 11'h020, 12'h123, 1'b1, 1'b0, 1'b0, 11'h010};
    vecs[1] = '{1'b0, 1'b1, 11'h7FF, 11'h020, 12'hABC, 1'b1, 1'b1, 1'b1, 11'h020};
    vecs[2] = '{1'b0, 1'b0, 11'h033, 11'h044, 12'h555, 1'b0, 1'b0, 1'b1, 11'h000};
    vecs[3] = '{1'b1, 1'b0, 11'h7FF, 11'h001, 12'h001, 1'b1, 1'b0, 1'b0, 11'h7FF};
    vecs[4] = '{1'b0, 1'b1, 11'h002, 11'h44C, 12'h0F0, 1'b1, 1'b1, 1'b1, 11'h44C};
    vecs[5] = '{1'b0, 1'b1, 11'h005, 11'h010, 12'hF00, 1'b1, 1'b1, 1'b1, 11'h010};

    for (int i = 0; i < MEM; i++) ref_mem[i] = init_pat(i);

    // ---------------- reset behaviour ----------------
    rst = 1'b1;
    mem_init = 1'b1;
    idle_inputs();
    bus.scan_addr = '0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.clr_color = '0;
    @(negedge clk);
    bus.scan_req = 1'b1;
    bus.wr_valid = 1'b1;
    bus.clr_start = 1'b1;
    #1;
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("rst_clr_busy", 32'(bus.clr_busy), 32'd0);
    chk("rst_scan_rvalid", 32'(bus.scan_rvalid), 32'd0);
    chk("rst_scan_rdata", 32'(bus.scan_rdata), 32'd0);
    @(negedge clk);
    idle_inputs();
    mem_init = 1'b0;
    rst = 1'b0;

    // ---------------- ownership vector table (clear idle) ----------------
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.scan_req  = vecs[i].scan_req;
      bus.wr_valid  = vecs[i].wr_valid;
      bus.scan_addr = vecs[i].scan_addr;
      bus.wr_addr   = vecs[i].wr_addr;
      bus.wr_data   = vecs[i].wr_data;
      #1;
      chk($sformatf("vec%0d_mem_en", i), 32'(bus.mem_en), 32'(vecs[i].exp_en));
      chk($sformatf("vec%0d_mem_we", i), 32'(bus.mem_we), 32'(vecs[i].exp_we));
      chk($sformatf("vec%0d_wr_ready", i), 32'(bus.wr_ready), 32'(vecs[i].exp_rdy));
      if (vecs[i].exp_en)
        chk($sformatf("vec%0d_mem_addr", i), 32'(bus.mem_addr), 32'(vecs[i].exp_addr));
      if (vecs[i].exp_we) begin
        chk($sformatf("vec%0d_mem_wdata", i), 32'(bus.mem_wdata), 32'(vecs[i].wr_data));
        ref_mem[vecs[i].wr_addr] = vecs[i].wr_data;
      end
    end

    // Write of 0xF00 to 0x010 above must read back through scanout
    @(negedge clk);
    idle_inputs();
    bus.scan_req  = 1'b1;
    bus.scan_addr = 11'h010;
    @(negedge clk);
    idle_inputs();
    #1;
    chk("wr_then_scan_rvalid", 32'(bus.scan_rvalid), 32'd1);
    chk("wr_then_scan_rdata", 32'(bus.scan_rdata), 32'h0F00);
    @(negedge clk);

    // ---------------- scanout hogging the port, then random mix ----------------
    run_mix(100, 1'b1);
    run_mix(300, 1'b0);

    // ---------------- plain clear ----------------
    @(negedge clk);
    idle_inputs();
    bus.clr_start = 1'b1;
    bus.clr_color = 12'h00F;
    #1;
    chk("clr_busy_at_start", 32'(bus.clr_busy), 32'd0);
    @(negedge clk);
    bus.clr_start = 1'b0;
    bus.clr_color = 12'hFFF;
    #1;
    chk("clr_busy_after_start", 32'(bus.clr_busy), 32'd1);
    n = 0; k = 0; bad = 0;
    while (bus.clr_busy && n < 3 * FW) begin
      if (!(bus.mem_en && bus.mem_we && (int'(bus.mem_addr) == k) && (bus.mem_wdata == 12'h00F)))
        bad++;
      k++; n++;
      @(negedge clk);
      #1;
    end
    chk("clr_busy_cycles", 32'(n), 32'(FW));
    chk("clr_write_sequence_bad", 32'(bad), 32'd0);
    for (int a = 0; a < FW; a++) ref_mem[a] = 12'h00F;
    scan_range(0, FW + 2);

    // ---------------- clear with a write held pending ----------------
    @(negedge clk);
    idle_inputs();
    bus.clr_start = 1'b1;
    bus.clr_color = 12'h0A5;
    for (int a = 0; a < FW; a++) ref_mem[a] = 12'h0A5;
    @(negedge clk);
    bus.clr_start = 1'b0;
    bus.wr_valid  = 1'b1;
    bus.wr_addr   = AW'(FW - 1);   // ahead of the clear: gets overwritten
    bus.wr_data   = 12'h777;
    wk = 0; n = 0; done = 0; alt_bad = 0; bad = 0; last = -1;
    prev_fire = 1'b0;
    #1;
    while (bus.clr_busy && n < 4 * FW) begin
      n++;
      fire = bus.wr_valid && bus.wr_ready;
      if (fire) begin
        if (!bus.mem_we || bus.mem_addr != bus.wr_addr) bad++;
        if (int'(bus.wr_addr) >= FW || int'(bus.wr_addr) < done) ref_mem[bus.wr_addr] = bus.wr_data;
        cur = 1;
      end else if (bus.mem_en && bus.mem_we) begin
        if (int'(bus.mem_addr) != done) bad++;
        done++;
        cur = 0;
      end else begin
        cur = 2;
        alt_bad++;
      end
      if (cur == last) alt_bad++;
      last = cur;
      prev_fire = fire;
      @(negedge clk);
      if (prev_fire) begin
        wk++;
        bus.wr_addr = (wk == 1) ? AW'(0) : AW'(FW + (wk % 200));
        bus.wr_data = DW'($urandom);
      end
      #1;
    end
    bus.wr_valid = 1'b0;
    chk_range("clr_with_wr_cycles", n, 2 * FW - 1, 2 * FW + 1);
    chk("clr_with_wr_grants", 32'(done), 32'(FW));
    chk("clr_with_wr_alternation_bad", 32'(alt_bad), 32'd0);
    chk("clr_with_wr_bus_bad", 32'(bad), 32'd0);
    scan_range(0, FW + 200);

    // ---------------- reset in the middle of a clear ----------------
    @(negedge clk);
    idle_inputs();
    bus.clr_start = 1'b1;
    bus.clr_color = 12'h3C3;
    @(negedge clk);
    bus.clr_start = 1'b0;
    n = 0;
    #1;
    while (!(bus.mem_en && bus.mem_we && bus.mem_addr == 11'd1000) && n < 2 * FW) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk_range("reach_counter_1000", n, 0, 2 * FW - 1);
    rst = 1'b1;
    #1;
    chk("abort_mem_en_in_rst", 32'(bus.mem_en), 32'd0);
    chk("abort_wr_ready_in_rst", 32'(bus.wr_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("abort_clr_busy", 32'(bus.clr_busy), 32'd0);
    chk("abort_mem_en", 32'(bus.mem_en), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("abort_stays_idle", 32'(bus.clr_busy), 32'd0);
    for (int a = 0; a < 1000; a++) ref_mem[a] = 12'h3C3;
    scan_range(998, 1001);

    @(negedge clk);
    idle_inputs();
    bus.clr_start = 1'b1;
    bus.clr_color = 12'h111;
    @(negedge clk);
    bus.clr_start = 1'b0;
    #1;
    chk("restart_busy", 32'(bus.clr_busy), 32'd1);
    chk("restart_first_addr", 32'(bus.mem_addr), 32'd0);
    chk("restart_first_data", 32'(bus.mem_wdata), 32'h111);
    n = 0;
    while (bus.clr_busy && n < 3 * FW) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk("restart_cycles", 32'(n), 32'(FW));
    for (int a = 0; a < FW; a++) ref_mem[a] = 12'h111;
    scan_range(0, 3);
    scan_range(FW - 2, FW + 1);

`ifdef VRAM_ARBITER_STATS_EN
    // ---------------- stall counter ----------------
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("stall_after_rst", 32'(stall_cnt), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.scan_req = 1'b1;
      bus.wr_valid = 1'b1;
    end
    @(negedge clk);
    idle_inputs();
    #1;
    chk("stall_5", 32'(stall_cnt), 32'd5);
    for (int i = 0; i < 65534 - 5; i++) begin
      @(negedge clk);
      bus.scan_req = 1'b1;
      bus.wr_valid = 1'b1;
    end
    @(negedge clk);
    idle_inputs();
    #1;
    chk("stall_fffe", 32'(stall_cnt), 32'hFFFE);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.scan_req = 1'b1;
      bus.wr_valid = 1'b1;
    end
    @(negedge clk);
    idle_inputs();
    #1;
    chk("stall_saturate", 32'(stall_cnt), 32'hFFFF);
`endif

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
